booth_radix4_multiplier: RTL and testbench



---
 rtl/booth_radix4_multiplier.sv | 119 +++++++++++
 tb/tb_booth_radix4_multiplier.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 (modified Booth) multiplier: retires two multiplier bits
// per cycle from operands latched at start, signed or unsigned per operation.
module booth_radix4_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   product
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER);
  localparam int EW   = WIDTH + 2;
  localparam int AW   = WIDTH + 3;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [EW-1:0]   m_r;
  logic [EW-1:0]   q_r;
  logic            qm1_r;
  logic [AW-1:0]   acc_r;

  logic [AW-1:0]   pp_s;
  logic [AW-1:0]   sum_s;
  logic [AW-1:0]   next_acc_s;
  logic [EW-1:0]   next_q_s;

  // Two extra bits make unsigned operands look positive to the Booth recoder.
  function automatic logic [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn) begin
      return {{2{v[WIDTH-1]}}, v};
    end else begin
      return {2'b00, v};
    end
  endfunction

  // Radix-4 digit selection; the multiplicand is one bit wider so 2M cannot overflow.
  function automatic logic [AW-1:0] booth_pp(input logic [2:0] trip, input logic [AW-1:0] m);
    case (trip)
      3'b001, 3'b010: return m;
      3'b011:         return {m[AW-2:0], 1'b0};
      3'b100:         return ~{m[AW-2:0], 1'b0} + {{(AW-1){1'b0}}, 1'b1};
      3'b101, 3'b110: return ~m + {{(AW-1){1'b0}}, 1'b1};
      default:        return {AW{1'b0}};
    endcase
  endfunction

  // One Booth step: add the partial product, then shift {acc, q} right by two.
  always_comb begin
    pp_s       = booth_pp({q_r[1:0], qm1_r}, {m_r[EW-1], m_r});
    sum_s      = acc_r + pp_s;
    next_acc_s = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
    next_q_s   = {sum_s[1:0], q_r[EW-1:2]};
  end

  // Control FSM and datapath registers; valid is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      m_r     <= {EW{1'b0}};
      q_r     <= {EW{1'b0}};
      qm1_r   <= 1'b0;
      acc_r   <= {AW{1'b0}};
      busy    <= 1'b0;
      valid   <= 1'b0;
      product <= {(2*WIDTH){1'b0}};
    end else begin
      valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            m_r     <= extend(multiplicand, signed_mode);
            q_r     <= extend(multiplier, signed_mode);
            qm1_r   <= 1'b0;
            acc_r   <= {AW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r <= next_acc_s;
          q_r   <= next_q_s;
          qm1_r <= q_r[1];
          if (cnt_r == LAST) begin
            // After WIDTH+2 bits of shifting the product spans acc's low bits and q.
            product <= {next_acc_s[WIDTH-3:0], next_q_s};
            valid   <= 1'b1;
            busy    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Bench for booth_radix4_multiplier: directed 8-bit cases plus randomized
// 8- and 16-bit operations checked against plain integer multiplication.
module tb_booth_radix4_multiplier;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  m8 = 8'h00, q8 = 8'h00;
  logic        busy8, valid8;
  logic [15:0] product8;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] m16 = 16'h0000, q16 = 16'h0000;
  logic        busy16, valid16;
  logic [31:0] product16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_radix4_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .multiplicand(m8), .multiplier(q8),
    .busy(busy8), .valid(valid8), .product(product8)
  );

  booth_radix4_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .signed_mode(sm16),
    .multiplicand(m16), .multiplier(q16),
    .busy(busy16), .valid(valid16), .product(product16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: ordinary integer product of the operands as signed or unsigned numbers.
  function automatic logic [31:0] ref_mul(input bit sm, input logic [15:0] m, input logic [15:0] q,
                                          input int w);
    longint a, b, p;
    if (w == 8) begin
      if (sm) begin
        a = longint'($signed(m[7:0]));
        b = longint'($signed(q[7:0]));
      end else begin
        a = longint'(m[7:0]);
        b = longint'(q[7:0]);
      end
    end else begin
      if (sm) begin
        a = longint'($signed(m));
        b = longint'($signed(q));
      end else begin
        a = longint'(m);
        b = longint'(q);
      end
    end
    p = a * b;
    if (w == 8) return {16'h0000, p[15:0]};
    return p[31:0];
  endfunction

  task automatic drive(input int w, input bit st, input bit sm, input logic [15:0] m, input logic [15:0] q);
    if (w == 8) begin
      start8 = st; sm8 = sm; m8 = m[7:0]; q8 = q[7:0];
    end else begin
      start16 = st; sm16 = sm; m16 = m; q16 = q;
    end
  endtask

  // Issue one operation, scramble inputs (including stray starts) while busy,
  // and finish in the valid cycle so a following call starts back-to-back.
  task automatic run_op(input int w, input bit sm, input logic [15:0] m, input logic [15:0] q,
                        input string tag);
    int iter = w / 2 + 1;
    logic [31:0] exp = ref_mul(sm, m, q, w);
    logic b, v;
    logic [31:0] p;
    drive(w, 1'b1, sm, m, q);
    tick();
    for (int k = 0; k < iter; k++) begin
      b = (w == 8) ? busy8 : busy16;
      v = (w == 8) ? valid8 : valid16;
      check({tag, " busy"}, {31'd0, b}, 32'd1);
      check({tag, " early_valid"}, {31'd0, v}, 32'd0);
      drive(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      tick();
    end
    start8 = 1'b0;
    start16 = 1'b0;
    b = (w == 8) ? busy8 : busy16;
    v = (w == 8) ? valid8 : valid16;
    p = (w == 8) ? {16'h0000, product8} : product16;
    check({tag, " valid"}, {31'd0, v}, 32'd1);
    check({tag, " busy_done"}, {31'd0, b}, 32'd0);
    check({tag, " product"}, p, exp);
  endtask

  initial begin
    #2;
    check("rst busy8", {31'd0, busy8}, 32'd0);
    check("rst valid8", {31'd0, valid8}, 32'd0);
    check("rst product8", {16'd0, product8}, 32'd0);
    check("rst busy16", {31'd0, busy16}, 32'd0);
    check("rst product16", product16, 32'd0);
    #20;
    reset = 1'b1;
    tick();

    run_op(8, 1'b1, 16'h00F9, 16'h0005, "neg7x5");
    check("neg7x5 const", {16'd0, product8}, 32'h0000FFDD);
    tick();
    check("hold valid", {31'd0, valid8}, 32'd0);
    check("hold product", {16'd0, product8}, 32'h0000FFDD);

    run_op(8, 1'b1, 16'h0080, 16'h0080, "min_sq");
    check("min_sq const", {16'd0, product8}, 32'h00004000);
    run_op(8, 1'b1, 16'h0080, 16'h007F, "min_max");
    check("min_max const", {16'd0, product8}, 32'h0000C080);
    run_op(8, 1'b0, 16'h00FF, 16'h00FF, "u255sq");
    check("u255sq const", {16'd0, product8}, 32'h0000FE01);
    run_op(8, 1'b1, 16'h00FF, 16'h00FF, "s_m1sq");
    check("s_m1sq const", {16'd0, product8}, 32'h00000001);
    tick();

    // start while busy with changed operands must be ignored
    drive(8, 1'b1, 1'b0, 16'h0003, 16'h0004);
    tick();
    drive(8, 1'b0, 1'b0, 16'h0009, 16'h0009);
    tick();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    check("busy_start valid", {31'd0, valid8}, 32'd1);
    check("busy_start product", {16'd0, product8}, 32'h0000000C);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("busy_start no2nd", {31'd0, valid8}, 32'd0);
      check("busy_start hold", {16'd0, product8}, 32'h0000000C);
    end

    for (int i = 0; i < 40; i++) begin
      run_op(8, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), "rand8");
    end

    for (int i = 0; i < 3000; i++) begin
      run_op(16, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), "rand16");
    end
    run_op(16, 1'b1, 16'h8000, 16'h8000, "min16_sq");
    run_op(16, 1'b0, 16'hFFFF, 16'hFFFF, "u16max_sq");

    // reset two cycles into an operation aborts it immediately
    tick();
    drive(8, 1'b1, 1'b1, 16'h0011, 16'h0022);
    tick();
    start8 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("abort busy", {31'd0, busy8}, 32'd0);
    check("abort valid", {31'd0, valid8}, 32'd0);
    check("abort product", {16'd0, product8}, 32'd0);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("abort no_valid", {31'd0, valid8}, 32'd0);
      check("abort idle", {31'd0, busy8}, 32'd0);
    end
    run_op(8, 1'b1, 16'h00FF, 16'h00FF, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
